// File: rtl/pu_window_sched_if.sv
// Stream, PU write-port and window-handshake bundle for the img2col window sequencer.
interface pu_window_sched_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WIN_W  = 8
);
    logic              job_start;
    logic [WIN_W-1:0]  num_win;
    logic              s_valid;
    logic [DATA_W-1:0] s_data1;
    logic [DATA_W-1:0] s_data2;
    logic              s_ready;
    logic              pu_start;
    logic              pu_round;
    logic [ADDR_W-1:0] pu_adrs1;
    logic [ADDR_W-1:0] pu_adrs2;
    logic [DATA_W-1:0] pu_new1;
    logic [DATA_W-1:0] pu_new2;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        output job_start, num_win, s_valid, s_data1, s_data2, out_ready,
        input  s_ready, pu_start, pu_round, pu_adrs1, pu_adrs2, pu_new1, pu_new2,
               out_valid, busy, done
    );

    modport slave (
        input  job_start, num_win, s_valid, s_data1, s_data2, out_ready,
        output s_ready, pu_start, pu_round, pu_adrs1, pu_adrs2, pu_new1, pu_new2,
               out_valid, busy, done
    );
endinterface

// File: rtl/pu_window_sched.sv
// Feeds one img2col PU a row of 5x5 windows: full load first, then 5-entry incremental loads.
module pu_window_sched #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned WIN_ENTRIES = 25,
    parameter int unsigned NEW_ENTRIES = 5,
    parameter int unsigned PU_LAT      = 2,
    parameter int unsigned WIN_W       = 8
) (
    input  logic             clk,
    input  logic             nrst,
    pu_window_sched_if.slave bus
);
    localparam int unsigned LAT_W = (PU_LAT > 1) ? $clog2(PU_LAT) : 1;
    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned CNT_W = WIN_W + 1;

    localparam logic [ADDR_W-1:0] ADDR_NONE = '1;
    localparam logic [ADDR_W-1:0] IDX_INCR  = ADDR_W'(WIN_ENTRIES - NEW_ENTRIES);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(PU_LAT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, PRESENT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [WIN_W-1:0]  num_win_q;
    logic [WIN_W-1:0]  win_cnt;
    logic [LAT_W-1:0]  lat_cnt;

    logic accept_c;
    logic pair_tail_c;
    logic last_beat_c;
    logic last_win_c;

    // Compares run one bit wider so idx+2 and win_cnt+1 never wrap.
    assign accept_c    = bus.s_valid & bus.s_ready;
    assign pair_tail_c = (IDX_W'(idx) + IDX_W'(1)) >= IDX_W'(WIN_ENTRIES);
    assign last_beat_c = (IDX_W'(idx) + IDX_W'(2)) >= IDX_W'(WIN_ENTRIES);
    assign last_win_c  = (CNT_W'(win_cnt) + CNT_W'(1)) == CNT_W'(num_win_q);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            idx           <= '0;
            num_win_q     <= '0;
            win_cnt       <= '0;
            lat_cnt       <= '0;
            bus.s_ready   <= 1'b0;
            bus.pu_start  <= 1'b0;
            bus.pu_round  <= 1'b0;
            bus.pu_adrs1  <= '0;
            bus.pu_adrs2  <= ADDR_NONE;
            bus.pu_new1   <= '0;
            bus.pu_new2   <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.pu_start <= 1'b0;
            bus.done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.job_start) begin
                        if (bus.num_win == '0) begin
                            bus.done <= 1'b1;
                        end else begin
                            num_win_q    <= bus.num_win;
                            win_cnt      <= '0;
                            idx          <= '0;
                            bus.pu_round <= 1'b0;
                            bus.s_ready  <= 1'b1;
                            bus.busy     <= 1'b1;
                            state        <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept_c) begin
                        bus.pu_start <= 1'b1;
                        bus.pu_adrs1 <= idx;
                        bus.pu_new1  <= bus.s_data1;
                        // Odd tail of the window: second word has no slot.
                        if (pair_tail_c) begin
                            bus.pu_adrs2 <= ADDR_NONE;
                            bus.pu_new2  <= '0;
                        end else begin
                            bus.pu_adrs2 <= idx + ADDR_W'(1);
                            bus.pu_new2  <= bus.s_data2;
                        end
                        idx <= idx + ADDR_W'(2);
                        if (last_beat_c) begin
                            bus.s_ready <= 1'b0;
                            lat_cnt     <= '0;
                            state       <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        bus.out_valid <= 1'b1;
                        state         <= PRESENT;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (last_win_c) begin
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            win_cnt      <= win_cnt + WIN_W'(1);
                            idx          <= IDX_INCR;
                            bus.pu_round <= 1'b1;
                            bus.s_ready  <= 1'b1;
                            state        <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pu_window_sched.sv
// Directed bench for pu_window_sched: per-cycle compare against a window-count model plus literal pins.
module tb_pu_window_sched;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 5;
    localparam int WIN_W       = 8;
    localparam int WIN_ENTRIES = 25;
    localparam int NEW_ENTRIES = 5;
    localparam int PU_LAT      = 2;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    pu_window_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIN_W(WIN_W)) bus ();

    pu_window_sched #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIN_ENTRIES(WIN_ENTRIES),
        .NEW_ENTRIES(NEW_ENTRIES), .PU_LAT(PU_LAT), .WIN_W(WIN_W)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus.slave)
    );

    // Model: expected outputs for the current cycle, derived from beat/latency/window counts.
    int m_busy, m_ready, m_start, m_round, m_ov, m_done;
    int m_a1, m_a2, m_n1, m_n2;
    int beats_left, lat_left, wins_left, next_addr;
    int acc_cnt = 0;

    int tests = 0, fails = 0;
    int cyc = 0, pu_cnt = 0, done_cnt = 0, ready_cnt = 0;
    int last_start = 0, last_a2 = 0, last_n1 = 0, ov_rise = 0, ov_prev = 0;
    int stream_on = 0, gap_pct = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_ready = 0; m_start = 0; m_round = 0; m_ov = 0; m_done = 0;
        m_a1 = 0; m_a2 = (1 << ADDR_W) - 1; m_n1 = 0; m_n2 = 0;
        beats_left = 0; lat_left = 0; wins_left = 0; next_addr = 0;
    endtask

    task automatic model_tick();
        m_start = 0;
        m_done  = 0;
        if (m_busy == 0) begin
            if (bus.job_start) begin
                if (int'(bus.num_win) == 0) begin
                    m_done = 1;
                end else begin
                    wins_left  = int'(bus.num_win);
                    next_addr  = 0;
                    m_round    = 0;
                    beats_left = (WIN_ENTRIES + 1) / 2;
                    m_busy     = 1;
                    m_ready    = 1;
                end
            end
        end else if (m_ready != 0) begin
            if (bus.s_valid) begin
                m_start = 1;
                m_a1    = next_addr;
                m_n1    = int'(bus.s_data1);
                if (next_addr + 1 < WIN_ENTRIES) begin
                    m_a2 = next_addr + 1;
                    m_n2 = int'(bus.s_data2);
                end else begin
                    m_a2 = (1 << ADDR_W) - 1;
                    m_n2 = 0;
                end
                next_addr += 2;
                beats_left--;
                acc_cnt++;
                if (beats_left == 0) begin
                    m_ready  = 0;
                    lat_left = PU_LAT;
                end
            end
        end else if (lat_left > 0) begin
            lat_left--;
            if (lat_left == 0) m_ov = 1;
        end else if (bus.out_ready) begin
            m_ov = 0;
            wins_left--;
            if (wins_left == 0) begin
                m_done = 1;
                m_busy = 0;
            end else begin
                next_addr  = WIN_ENTRIES - NEW_ENTRIES;
                m_round    = 1;
                beats_left = (NEW_ENTRIES + 1) / 2;
                m_ready    = 1;
            end
        end
    endtask

    task automatic tick_pos();
        @(posedge clk);
        if (!nrst) model_reset();
        else model_tick();
    endtask

    // Per-cycle compare, event counters and stream drive, all on the falling edge.
    task automatic tick_neg();
        @(negedge clk);
        cyc++;
        chk("cyc_pu_start", int'(bus.pu_start), m_start);
        chk("cyc_pu_round", int'(bus.pu_round), m_round);
        chk("cyc_pu_adrs1", int'(bus.pu_adrs1), m_a1);
        chk("cyc_pu_adrs2", int'(bus.pu_adrs2), m_a2);
        chk("cyc_pu_new1", int'(bus.pu_new1), m_n1);
        chk("cyc_pu_new2", int'(bus.pu_new2), m_n2);
        chk("cyc_s_ready", int'(bus.s_ready), m_ready);
        chk("cyc_out_valid", int'(bus.out_valid), m_ov);
        chk("cyc_busy", int'(bus.busy), m_busy);
        chk("cyc_done", int'(bus.done), m_done);
        if (bus.pu_start) begin
            pu_cnt++;
            last_start = cyc;
            last_a2    = int'(bus.pu_adrs2);
            last_n1    = int'(bus.pu_new1);
        end
        if (bus.done) done_cnt++;
        if (bus.s_ready) ready_cnt++;
        if (bus.out_valid && ov_prev == 0) ov_rise = cyc;
        ov_prev = int'(bus.out_valid);
        bus.s_valid = (stream_on != 0) && ($urandom_range(0, 99) >= gap_pct);
        bus.s_data1 = DATA_W'(2 * acc_cnt + 1);
        bus.s_data2 = DATA_W'(2 * acc_cnt + 2);
        #1;
    endtask

    task automatic step();
        tick_pos();
        tick_neg();
    endtask

    task automatic start_job(input int n);
        bus.job_start = 1'b1;
        bus.num_win   = WIN_W'(n);
        step();
        bus.job_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int k = 0;
        while (done_cnt == base && k < budget) begin
            step();
            k++;
        end
        chk(name, done_cnt - base, 1);
    endtask

    int bp, bd, br;

    initial begin
        model_reset();
        bus.job_start = 1'b0;
        bus.num_win   = '0;
        bus.s_valid   = 1'b0;
        bus.s_data1   = '0;
        bus.s_data2   = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_adrs2", int'(bus.pu_adrs2), 31);
        chk("rst_s_ready", int'(bus.s_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        nrst = 1'b1;
        stream_on = 1;
        step();

        // Single window, gap-free stream carrying 1..26.
        bp = pu_cnt; bd = done_cnt;
        start_job(1);
        wait_done(bd, 200, "job1_done");
        chk("job1_pulses", pu_cnt - bp, 13);
        chk("job1_last_a2", last_a2, 31);
        chk("job1_last_n1", last_n1, 25);
        chk("job1_latency", ov_rise - last_start, 2);
        step();
        chk("job1_idle_busy", int'(bus.busy), 0);

        // Three windows: 13 + 3 + 3 beats.
        bp = pu_cnt; bd = done_cnt;
        start_job(3);
        wait_done(bd, 300, "job3_done");
        chk("job3_pulses", pu_cnt - bp, 19);
        repeat (3) step();
        chk("job3_single_done", done_cnt - bd, 1);

        // Full load with ~50% stream gaps.
        gap_pct = 50;
        bp = pu_cnt; bd = done_cnt;
        start_job(1);
        wait_done(bd, 400, "gap_done");
        chk("gap_pulses", pu_cnt - bp, 13);
        chk("gap_last_a2", last_a2, 31);
        gap_pct = 0;

        // Consumer stalls in PRESENT for 10 cycles.
        bus.out_ready = 1'b0;
        bp = pu_cnt; bd = done_cnt;
        start_job(2);
        for (int k = 0; k < 100 && !bus.out_valid; k++) step();
        chk("stall_present_reached", int'(bus.out_valid), 1);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("stall_out_valid", int'(bus.out_valid), 1);
            chk("stall_s_ready", int'(bus.s_ready), 0);
            chk("stall_pu_start", int'(bus.pu_start), 0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("stall_resume_ready", int'(bus.s_ready), 1);
        chk("stall_resume_round", int'(bus.pu_round), 1);
        wait_done(bd, 200, "stall_done");
        chk("stall_pulses", pu_cnt - bp, 16);

        // Zero-window job: immediate done, stream never opened.
        br = ready_cnt; bd = done_cnt;
        start_job(0);
        chk("zero_done_pulse", int'(bus.done), 1);
        repeat (4) step();
        chk("zero_no_ready", ready_cnt - br, 0);
        chk("zero_busy", int'(bus.busy), 0);

        // job_start while loading is ignored.
        bp = pu_cnt; bd = done_cnt;
        start_job(2);
        repeat (4) step();
        bus.job_start = 1'b1;
        bus.num_win   = WIN_W'(7);
        step();
        bus.job_start = 1'b0;
        wait_done(bd, 300, "ignore_done");
        chk("ignore_pulses", pu_cnt - bp, 16);
        repeat (5) step();
        chk("ignore_stays_idle", int'(bus.busy), 0);

        // Asynchronous reset in the middle of the 7th beat, then a fresh job.
        bp = pu_cnt; bd = done_cnt;
        start_job(1);
        for (int k = 0; k < 100 && (pu_cnt - bp) < 6; k++) step();
        chk("rst_mid_reached", pu_cnt - bp, 6);
        tick_pos();
        #2 nrst = 1'b0;
        model_reset();
        #1;
        chk("arst_pu_start", int'(bus.pu_start), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_s_ready", int'(bus.s_ready), 0);
        chk("arst_adrs2", int'(bus.pu_adrs2), 31);
        chk("arst_new1", int'(bus.pu_new1), 0);
        tick_neg();
        step();
        nrst = 1'b1;
        step();
        bp = pu_cnt; bd = done_cnt;
        start_job(1);
        chk("post_rst_round", int'(bus.pu_round), 0);
        wait_done(bd, 200, "post_rst_done");
        chk("post_rst_pulses", pu_cnt - bp, 13);

        // Largest window count: counter compare must not wrap.
        bp = pu_cnt; bd = done_cnt;
        start_job(255);
        wait_done(bd, 5000, "max_done");
        chk("max_pulses", pu_cnt - bp, 13 + 254 * 3);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
